// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. It decodes the IR
//   opcode and steps each instruction through FETCH / DECODE / EXECUTE /
//   MEM / WB. Along the way it drives the datapath selects, the write
//   enables and the 2-bit ALUOp code that ALU control consumes.
//   ALUOp: 00 = add (address / PC+4), 01 = sub (beq compare),
//          10 = use the funct field (R-type).
//
// Parameters
//   MEM_WAIT_EN  1: FETCH/MEMRD/MEMWR hold until mem_ready=1
//                0: mem_ready is ignored and treated as always 1
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode[5:0]         IR[31:26], only looked at in DECODE
//   mem_ready           memory completes its access this cycle
//   PCWrite, Branch     unconditional / zero-conditional PC load
//   PCSrc[1:0]          00 ALU result, 01 ALUOut, 10 jump target
//   IorD                0 PC addresses memory, 1 ALUOut addresses memory
//   MemWrite, IRWrite   memory write strobe, IR load
//   RegDst, MemtoReg    0 rt / 1 rd ; 0 ALUOut / 1 MDR
//   RegWrite            register file write
//   ALUSrcA             0 PC, 1 A
//   ALUSrcB[1:0]        00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   ALUOp[1:0]          to ALU control
//   instr_done          high on the final cycle of every instruction
//   illegal_op          one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]          current state encoding, for debug
// ----------------------------------------------------------------------------
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t cur_state;
  logic   is_sw;
  logic   ready;
  logic   op_legal;

  // With the handshake disabled, every memory access finishes in one cycle.
  assign ready    = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign op_legal = (opcode == OP_R)   || (opcode == OP_J)  ||
                    (opcode == OP_BEQ) || (opcode == OP_ADDI) ||
                    (opcode == OP_LW)  || (opcode == OP_SW);
  assign state    = cur_state;

  // State register and next-state sequencing. The lw/sw distinction is
  // captured in DECODE, because the IR opcode may not be stable by MEMADR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      is_sw     <= 1'b0;
    end else begin
      case (cur_state)
        FETCH:  if (ready) cur_state <= DECODE;
        DECODE: begin
          is_sw <= (opcode == OP_SW);
          case (opcode)
            OP_LW, OP_SW: cur_state <= MEMADR;
            OP_R:         cur_state <= EXEC;
            OP_BEQ:       cur_state <= BRANCH;
            OP_ADDI:      cur_state <= ADDIEX;
            OP_J:         cur_state <= JUMP;
            default:      cur_state <= FETCH;
          endcase
        end
        MEMADR: cur_state <= is_sw ? MEMWR : MEMRD;
        MEMRD:  if (ready) cur_state <= MEMWB;
        MEMWR:  if (ready) cur_state <= FETCH;
        EXEC:   cur_state <= ALUWB;
        ADDIEX: cur_state <= ADDIWB;
        default: cur_state <= FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state register. The only inputs that are
  // allowed to leak through are the memory handshake and the opcode legality
  // check in DECODE. Everything is forced to zero while reset is asserted,
  // so no write enable can survive an abort, even for the remainder of the cycle.
  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (cur_state)
        FETCH: begin
          ALUSrcB = 2'b01;
          IRWrite = ready;
          PCWrite = ready;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~op_legal;
          instr_done = ~op_legal;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: IorD = 1'b1;
        MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = ready;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUOp      = 2'b01;
          Branch     = 1'b1;
          PCSrc      = 2'b01;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          PCSrc      = 2'b10;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. The expected behaviour of each
//   instruction comes from a list of the states it visits. A memory state in
//   that list repeats while mem_ready is low. Expected outputs per cycle come
//   from the per-state output table.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg;
  logic       RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] state;

  int tests    = 0;
  int failures = 0;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal_op;
  } outs_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t actual_outs();
    outs_t a;
    a = {PCWrite, Branch, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
         RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op};
    return a;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == OP_R || op == OP_J || op == OP_BEQ || op == OP_ADDI ||
           op == OP_LW || op == OP_SW;
  endfunction

  // Output table, one row per state, as a function of the handshake.
  function automatic outs_t exp_out(input int st, input bit rdy, input logic [5:0] op);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.alusrcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy; end
      1:  begin o.alusrcb = 2'b11; o.illegal_op = !legal(op); o.instr_done = !legal(op); end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  o.iord = 1;
      4:  begin o.memtoreg = 1; o.regwrite = 1; o.instr_done = 1; end
      5:  begin o.iord = 1; o.memwrite = 1; o.instr_done = rdy; end
      6:  begin o.alusrca = 1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1; o.regwrite = 1; o.instr_done = 1; end
      8:  begin o.alusrca = 1; o.aluop = 2'b01; o.branch = 1; o.pcsrc = 2'b01; o.instr_done = 1; end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      10: begin o.regwrite = 1; o.instr_done = 1; end
      11: begin o.pcsrc = 2'b10; o.pcwrite = 1; o.instr_done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Runs one instruction against the model. stall_st/stall_n are used for a
  // directed stall count in one state. rnd instead gives random mem_ready with
  // at most 3 stalls in a row. done_cyc is the cycle (1-based) where the DUT
  // first raised instr_done.
  task automatic run_instr(input logic [5:0] op, input bit rnd, input int stall_st,
                           input int stall_n, output int done_cyc);
    int  seq[$];
    int  idx, cyc, stalls, consec, cur;
    bit  rdy, waiting;
    outs_t exp, act;
    case (op)
      OP_LW:   seq = '{0, 1, 2, 3, 4};
      OP_SW:   seq = '{0, 1, 2, 5};
      OP_R:    seq = '{0, 1, 6, 7};
      OP_BEQ:  seq = '{0, 1, 8};
      OP_ADDI: seq = '{0, 1, 9, 10};
      OP_J:    seq = '{0, 1, 11};
      default: seq = '{0, 1};
    endcase
    idx = 0; cyc = 0; stalls = 0; consec = 0; done_cyc = -1;
    while (idx < seq.size() && cyc < 64) begin
      @(negedge clk);
      cur = seq[idx];
      if (rnd) rdy = (consec >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
      else     rdy = !(cur == stall_st && stalls < stall_n);
      if (!rdy) consec++; else consec = 0;
      if (cur == stall_st && !rdy) stalls++;
      waiting   = (cur == 0 || cur == 3 || cur == 5) && !rdy;
      mem_ready = rdy;
      opcode    = (cur == 1) ? op : 6'($urandom);
      #1;
      exp = exp_out(cur, rdy, op);
      act = actual_outs();
      tests++;
      if (state !== 4'(cur) || act !== exp) begin
        failures++;
        $display("[TB] FAIL op=%b cycle %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                 op, cyc, state, act, cur, exp);
      end
      if (instr_done === 1'b1 && done_cyc < 0) done_cyc = cyc + 1;
      if (!waiting) idx++;
      cyc++;
    end
    if (cyc >= 64) begin
      failures++;
      $display("[TB] FAIL op=%b timeout: got %0d cycles, want fewer than 64", op, cyc);
    end
  endtask

  task automatic test_reset();
    outs_t act;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    repeat (2) @(negedge clk);
    #1;
    act = actual_outs();
    tests++;
    if (state !== 4'd0 || act !== '0) begin
      failures++;
      $display("[TB] FAIL reset_hold: got state=%0d outs=%h, want state=0 outs=0", state, act);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    tests++;
    if (state !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1 ||
        ALUSrcB !== 2'b01 || ALUOp !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_release: got state=%0d IRWrite=%b PCWrite=%b ALUSrcB=%b ALUOp=%b, want 0 1 1 01 00",
               state, IRWrite, PCWrite, ALUSrcB, ALUOp);
    end
  endtask

  task automatic test_cycles(input string name, input logic [5:0] op, input int stall_st,
                             input int stall_n, input int want);
    int dc;
    run_instr(op, 1'b0, stall_st, stall_n, dc);
    tests++;
    if (dc !== want) begin
      failures++;
      $display("[TB] FAIL %s_length: got instr_done at cycle %0d, want %0d", name, dc, want);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    logic [5:0] op;
    int dc;
    ops = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, 6'b111111};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 6'b111111) op = 6'($urandom);
      run_instr(op, 1'b1, -1, 0, dc);
      tests++;
      if (dc < 0) begin
        failures++;
        $display("[TB] FAIL random_done op=%b: got no instr_done, want one", op);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    outs_t act;
    int dc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      opcode    = OP_SW;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    tests++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      failures++;
      $display("[TB] FAIL memwr_wait: got state=%0d MemWrite=%b, want 5 1", state, MemWrite);
    end
    #1 rst_n = 1'b0;
    #1;
    act = actual_outs();
    tests++;
    if (state !== 4'd0 || act !== '0) begin
      failures++;
      $display("[TB] FAIL reset_abort: got state=%0d outs=%h, want state=0 outs=0", state, act);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    test_cycles("after_abort", OP_R, -1, 0, 4);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cycles("rtype", OP_R,    -1, 0, 4);
    test_cycles("lw_stall", OP_LW, 3, 2, 7);
    test_cycles("lw", OP_LW,      -1, 0, 5);
    test_cycles("sw", OP_SW,      -1, 0, 4);
    test_cycles("sw_stall", OP_SW, 5, 2, 6);
    test_cycles("beq", OP_BEQ,    -1, 0, 3);
    test_cycles("illegal", 6'b111111, -1, 0, 2);
    test_cycles("jump", OP_J,     -1, 0, 3);
    test_cycles("addi", OP_ADDI,  -1, 0, 4);
    test_cycles("fetch_stall", OP_R, 0, 3, 7);
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
